// File: rtl/mips_multicycle_datapath.sv
// Multicycle MIPS-32 datapath: PC/IR/MDR/A/B/ALUOut registers, 32x32 register file,
// ALU and ALU control, steered each cycle by the control word from the control unit.
module mips_multicycle_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        IorD,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemToReg,
  input  logic        IRWrite,
  input  logic        RegDst,
  input  logic        RegWrite,
  input  logic        ALUSrcA,
  input  logic        PCWrite,
  input  logic        PCWriteCond,
  input  logic [1:0]  ALUSrcB,
  input  logic [1:0]  ALUOp,
  input  logic [1:0]  PCSource,
  output logic [5:0]  Opcode,
  output logic [5:0]  Funct,
  output logic        Zero,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc_out
);

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  logic [31:0] pc, ir, mdr, a, b, alu_out;
  logic [31:0] regs [32];
  logic [31:0] rs_val, rt_val, imm_ext;
  logic [31:0] src_a, src_b, alu_result, next_pc, wr_data;
  logic [4:0]  wr_addr;
  logic [2:0]  alu_ctrl;
  logic        pc_en;

  assign imm_ext = {{16{ir[15]}}, ir[15:0]};

  // $0 is forced to read zero regardless of storage contents
  assign rs_val = (ir[25:21] == 5'd0) ? 32'd0 : regs[ir[25:21]];
  assign rt_val = (ir[20:16] == 5'd0) ? 32'd0 : regs[ir[20:16]];

  assign src_a = ALUSrcA ? a : pc;

  always_comb begin
    src_b = b;
    case (ALUSrcB)
      2'b00:   src_b = b;
      2'b01:   src_b = 32'd4;
      2'b10:   src_b = imm_ext;
      default: src_b = {imm_ext[29:0], 2'b00};
    endcase
  end

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (ALUOp)
      2'b01: alu_ctrl = ALU_SUB;
      2'b10: begin
        case (ir[5:0])
          6'h22:   alu_ctrl = ALU_SUB;
          6'h24:   alu_ctrl = ALU_AND;
          6'h25:   alu_ctrl = ALU_OR;
          6'h2A:   alu_ctrl = ALU_SLT;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

  always_comb begin
    alu_result = src_a + src_b;
    case (alu_ctrl)
      ALU_SUB: alu_result = src_a - src_b;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_SLT: alu_result = {31'd0, ($signed(src_a) < $signed(src_b))};
      default: alu_result = src_a + src_b;
    endcase
  end

  assign Zero = (alu_result == 32'd0);

  always_comb begin
    next_pc = alu_result;
    case (PCSource)
      2'b00:   next_pc = alu_result;
      2'b01:   next_pc = alu_out;
      2'b10:   next_pc = {pc[31:28], ir[25:0], 2'b00};
      default: next_pc = pc;
    endcase
  end

  assign pc_en   = PCWrite | (PCWriteCond & Zero);
  assign wr_addr = RegDst ? ir[15:11] : ir[20:16];
  assign wr_data = MemToReg ? mdr : alu_out;

  always_ff @(posedge Clk) begin
    if (reset) begin
      pc      <= RESET_PC;
      ir      <= 32'd0;
      mdr     <= 32'd0;
      a       <= 32'd0;
      b       <= 32'd0;
      alu_out <= 32'd0;
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else begin
      if (pc_en) pc <= next_pc;
      if (IRWrite) ir <= mem_rdata;
      mdr     <= mem_rdata;
      a       <= rs_val;
      b       <= rt_val;
      alu_out <= alu_result;
      if (RegWrite && (wr_addr != 5'd0)) regs[wr_addr] <= wr_data;
    end
  end

  assign Opcode    = ir[31:26];
  assign Funct     = ir[5:0];
  assign mem_addr  = IorD ? alu_out : pc;
  assign mem_wdata = b;
  assign mem_read  = MemRead;
  assign mem_write = MemWrite;
  assign pc_out    = pc;

endmodule

// File: tb/tb_mips_multicycle_datapath.sv
// Bench for mips_multicycle_datapath: the bench plays control unit and memory,
// queues expected values as stimulus is applied and compares when outputs appear.
module tb_mips_multicycle_datapath;

  logic        Clk = 1'b0;
  logic        reset;
  logic        IorD, MemRead, MemWrite, MemToReg, IRWrite, RegDst, RegWrite;
  logic        ALUSrcA, PCWrite, PCWriteCond;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic [5:0]  Opcode, Funct;
  logic        Zero;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;
  logic        mem_read, mem_write;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_run  = 0;
  int   n_fail = 0;

  mips_multicycle_datapath #(.RESET_PC(32'h0000_0100)) dut (
    .Clk(Clk), .reset(reset),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
    .IRWrite(IRWrite), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata), .pc_out(pc_out)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] alu_model(input logic [31:0] x, input logic [31:0] y,
                                            input logic [5:0] f);
    case (f)
      6'h22:   return x - y;
      6'h24:   return x & y;
      6'h25:   return x | y;
      6'h2A:   return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: return x + y;
    endcase
  endfunction

  task automatic clear_ctrl();
    IorD = 0; MemRead = 0; MemWrite = 0; MemToReg = 0; IRWrite = 0; RegDst = 0;
    RegWrite = 0; ALUSrcA = 0; PCWrite = 0; PCWriteCond = 0;
    ALUSrcB = 2'b00; ALUOp = 2'b00; PCSource = 2'b00;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // IR load edge followed by one edge so A/B reflect the new IR fields
  task automatic load_ir(input logic [31:0] instr);
    clear_ctrl();
    mem_rdata = instr;
    IRWrite = 1;
    tick();
    IRWrite = 0;
    tick();
  endtask

  task automatic read_reg(input logic [4:0] r, output logic [31:0] v);
    load_ir({6'h00, 5'd0, r, 16'h0000});
    v = mem_wdata;
  endtask

  task automatic write_reg(input logic [4:0] r, input logic [31:0] v);
    load_ir({6'h23, 5'd0, r, 16'h0000});
    mem_rdata = v;
    tick();
    MemToReg = 1; RegWrite = 1; RegDst = 0;
    tick();
    clear_ctrl();
  endtask

  task automatic test_reset();
    logic [31:0] v;
    clear_ctrl();
    mem_rdata = 32'h0;
    reset = 1;
    tick();
    tick();
    reset = 0;
    sb.push_back('{name:"reset_pc", val:32'h0000_0100});
    sb.push_back('{name:"reset_opcode", val:32'd0});
    sb.push_back('{name:"reset_funct", val:32'd0});
    sb.push_back('{name:"reset_wdata", val:32'd0});
    e = sb.pop_front(); n_run++;
    if (pc_out !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, pc_out, e.val); end
    e = sb.pop_front(); n_run++;
    if ({26'd0, Opcode} !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, Opcode, e.val); end
    e = sb.pop_front(); n_run++;
    if ({26'd0, Funct} !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, Funct, e.val); end
    e = sb.pop_front(); n_run++;
    if (mem_wdata !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, mem_wdata, e.val); end
    for (int r = 1; r < 32; r += 10) begin
      sb.push_back('{name:$sformatf("reset_reg%0d", r), val:32'd0});
      read_reg(r[4:0], v);
      e = sb.pop_front(); n_run++;
      if (v !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, v, e.val); end
    end
  endtask

  task automatic test_fetch();
    clear_ctrl();
    mem_rdata = 32'h8C8A_0004;
    MemRead = 1; IRWrite = 1; ALUSrcB = 2'b01; PCWrite = 1;
    sb.push_back('{name:"fetch_addr", val:32'h0000_0100});
    sb.push_back('{name:"fetch_memread", val:32'd1});
    sb.push_back('{name:"fetch_opcode", val:32'h23});
    sb.push_back('{name:"fetch_funct", val:32'h04});
    sb.push_back('{name:"fetch_pc", val:32'h0000_0104});
    #1;
    e = sb.pop_front(); n_run++;
    if (mem_addr !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, mem_addr, e.val); end
    e = sb.pop_front(); n_run++;
    if ({31'd0, mem_read} !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, mem_read, e.val); end
    tick();
    clear_ctrl();
    e = sb.pop_front(); n_run++;
    if ({26'd0, Opcode} !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, Opcode, e.val); end
    e = sb.pop_front(); n_run++;
    if ({26'd0, Funct} !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, Funct, e.val); end
    e = sb.pop_front(); n_run++;
    if (pc_out !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, pc_out, e.val); end
  endtask

  task automatic test_rtype();
    logic [31:0] ta [8] = '{32'd5, 32'hFFFF_FFFF, 32'd7, 32'hF0F0_1234,
                            32'hF0F0_1234, 32'd1, 32'd3, 32'hFFFF_FFFF};
    logic [31:0] tb [8] = '{32'd7, 32'd1, 32'd5, 32'h0FF0_FF00,
                            32'h0FF0_FF00, 32'hFFFF_FFFF, 32'd4, 32'd1};
    logic [5:0]  tf [8] = '{6'h20, 6'h2A, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h20};
    logic [31:0] v;
    for (int i = 0; i < 8; i++) begin
      write_reg(5'd1, ta[i]);
      write_reg(5'd2, tb[i]);
      sb.push_back('{name:$sformatf("rtype%0d_f%h", i, tf[i]), val:alu_model(ta[i], tb[i], tf[i])});
      load_ir({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, tf[i]});
      ALUSrcA = 1; ALUSrcB = 2'b00; ALUOp = 2'b10;
      tick();
      clear_ctrl();
      RegDst = 1; RegWrite = 1;
      tick();
      clear_ctrl();
      read_reg(5'd3, v);
      e = sb.pop_front(); n_run++;
      if (v !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, v, e.val); end
    end
  endtask

  task automatic test_lw();
    logic [31:0] v;
    logic [4:0]  rts [2] = '{5'd5, 5'd0};
    logic [31:0] want [2] = '{32'hDEAD_BEEF, 32'd0};
    write_reg(5'd4, 32'h0000_0010);
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{name:$sformatf("lw%0d_addr", i), val:32'h0000_0014});
      sb.push_back('{name:$sformatf("lw%0d_reg%0d", i, rts[i]), val:want[i]});
      load_ir({6'h23, 5'd4, rts[i], 16'h0004});
      ALUSrcA = 1; ALUSrcB = 2'b10;
      tick();
      clear_ctrl();
      IorD = 1; MemRead = 1;
      mem_rdata = 32'hDEAD_BEEF;
      #1;
      e = sb.pop_front(); n_run++;
      if (mem_addr !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, mem_addr, e.val); end
      tick();
      clear_ctrl();
      MemToReg = 1; RegDst = 0; RegWrite = 1;
      tick();
      clear_ctrl();
      read_reg(rts[i], v);
      e = sb.pop_front(); n_run++;
      if (v !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, v, e.val); end
    end
    // negative displacement through the sign extender
    sb.push_back('{name:"lw_neg_addr", val:32'h0000_000C});
    load_ir({6'h23, 5'd4, 5'd5, 16'hFFFC});
    ALUSrcA = 1; ALUSrcB = 2'b10;
    tick();
    clear_ctrl();
    IorD = 1;
    #1;
    e = sb.pop_front(); n_run++;
    if (mem_addr !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, mem_addr, e.val); end
    clear_ctrl();
  endtask

  task automatic test_branch();
    logic [31:0] rt_vals [2] = '{32'd9, 32'd8};
    logic [31:0] zero_exp [2] = '{32'd1, 32'd0};
    write_reg(5'd6, 32'd9);
    sb.push_back('{name:"pc_to_zero", val:32'd0});
    load_ir(32'h2000_0000);
    ALUSrcA = 1; ALUSrcB = 2'b10; PCSource = 2'b00; PCWrite = 1;
    tick();
    clear_ctrl();
    e = sb.pop_front(); n_run++;
    if (pc_out !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, pc_out, e.val); end
    for (int i = 0; i < 2; i++) begin
      write_reg(5'd7, rt_vals[i]);
      sb.push_back('{name:$sformatf("beq%0d_zero", i), val:zero_exp[i]});
      sb.push_back('{name:$sformatf("beq%0d_pc", i), val:32'h0000_0040});
      load_ir({6'h04, 5'd6, 5'd7, 16'h0010});
      ALUSrcA = 0; ALUSrcB = 2'b11; ALUOp = 2'b00;
      tick();
      clear_ctrl();
      ALUSrcA = 1; ALUSrcB = 2'b00; ALUOp = 2'b01; PCWriteCond = 1; PCSource = 2'b01;
      #1;
      e = sb.pop_front(); n_run++;
      if ({31'd0, Zero} !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, Zero, e.val); end
      tick();
      clear_ctrl();
      e = sb.pop_front(); n_run++;
      if (pc_out !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, pc_out, e.val); end
    end
  endtask

  task automatic test_jump();
    write_reg(5'd8, 32'h3000_0000);
    sb.push_back('{name:"pc_set", val:32'h3000_0004});
    sb.push_back('{name:"jump_pc", val:32'h3000_0040});
    sb.push_back('{name:"pc_hold", val:32'h3000_0040});
    load_ir({6'h08, 5'd8, 5'd0, 16'h0004});
    ALUSrcA = 1; ALUSrcB = 2'b10; PCWrite = 1;
    tick();
    clear_ctrl();
    e = sb.pop_front(); n_run++;
    if (pc_out !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, pc_out, e.val); end
    load_ir(32'h0800_0010);
    PCSource = 2'b10; PCWrite = 1;
    tick();
    clear_ctrl();
    e = sb.pop_front(); n_run++;
    if (pc_out !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, pc_out, e.val); end
    PCSource = 2'b11; PCWrite = 1;
    tick();
    clear_ctrl();
    e = sb.pop_front(); n_run++;
    if (pc_out !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, pc_out, e.val); end
  endtask

  task automatic test_no_bypass();
    write_reg(5'd9, 32'h1111_1111);
    sb.push_back('{name:"nobypass_old", val:32'h1111_1111});
    sb.push_back('{name:"nobypass_new", val:32'h2222_2222});
    load_ir({6'h23, 5'd0, 5'd9, 16'h0000});
    mem_rdata = 32'h2222_2222;
    tick();
    MemToReg = 1; RegWrite = 1;
    tick();
    clear_ctrl();
    e = sb.pop_front(); n_run++;
    if (mem_wdata !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, mem_wdata, e.val); end
    tick();
    e = sb.pop_front(); n_run++;
    if (mem_wdata !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, mem_wdata, e.val); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    write_reg(5'd5, 32'hA5A5_A5A5);
    load_ir({6'h23, 5'd0, 5'd5, 16'h0000});
    sb.push_back('{name:"midreset_pc", val:32'h0000_0100});
    sb.push_back('{name:"midreset_opcode", val:32'd0});
    sb.push_back('{name:"midreset_wdata", val:32'd0});
    sb.push_back('{name:"midreset_reg5", val:32'd0});
    MemRead = 1; IRWrite = 1; ALUSrcB = 2'b01; PCWrite = 1; RegWrite = 1; MemToReg = 1;
    mem_rdata = 32'hFFFF_FFFF;
    reset = 1;
    tick();
    tick();
    reset = 0;
    clear_ctrl();
    e = sb.pop_front(); n_run++;
    if (pc_out !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, pc_out, e.val); end
    e = sb.pop_front(); n_run++;
    if ({26'd0, Opcode} !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, Opcode, e.val); end
    e = sb.pop_front(); n_run++;
    if (mem_wdata !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, mem_wdata, e.val); end
    read_reg(5'd5, v);
    e = sb.pop_front(); n_run++;
    if (v !== e.val) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, v, e.val); end
  endtask

  initial begin
    reset = 1;
    mem_rdata = 32'h0;
    clear_ctrl();
    test_reset();
    test_fetch();
    test_rtype();
    test_lw();
    test_branch();
    test_jump();
    test_no_bypass();
    test_reset_mid();
    if (sb.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
